// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder front end.
package serial_adder_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2 of the digit count, never narrower than 1 bit.
  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_2bit_ctrl_add2_slice.sv
// add2_slice: combinational 2-bit ripple adder built from two full-adder bit cells.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic w_c1;

  // Bit 0 cell generates the internal carry, bit 1 cell consumes it.
  always_comb begin
    w_c1 = (a[0] & b[0]) | ((a[0] ^ b[0]) & ci);
    s[0] = a[0] ^ b[0] ^ ci;
    s[1] = a[1] ^ b[1] ^ w_c1;
    co   = (a[1] & b[1]) | ((a[1] ^ b[1]) & w_c1);
  end

endmodule

// File: rtl/serial_adder_2bit_ctrl.sv
// serial_adder_2bit_ctrl: adds WIDTH-bit operands two bits per cycle through
// one add2_slice, LSB digit first, with valid/ready on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a - b.
module serial_adder_2bit_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam int CW   = cnt_w(NDIG);

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [1:0]       w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  add2_slice u_slice (
    .a  (r_a_sr[1:0]),
    .b  (r_b_sr[1:0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state and handshake outputs; in_ready is held low during reset.
  always_comb begin
    w_nstate  = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) w_nstate = RUN;
      end
      RUN: begin
        if (w_last) w_nstate = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry and digit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          // Shift the new digit in from the top; the concat form also covers WIDTH=2.
          r_sum_sr <= WIDTH'({w_s, r_sum_sr} >> DIGIT_W);
          r_a_sr   <= r_a_sr >> DIGIT_W;
          r_b_sr   <= r_b_sr >> DIGIT_W;
          r_carry  <= w_co;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result is only presented while the result is being offered.
  assign sum  = out_valid ? r_sum_sr : '0;
  assign cout = out_valid & r_carry;

endmodule
